// File: rtl/stream_packet_arbiter_if.sv
// Stream bundle for stream_packet_arbiter: N upstream AXI4-Stream ports and one
// downstream port carrying the source id of each beat.
interface stream_packet_arbiter_if #(
  parameter int NUM_PORTS = 4,
  parameter int DATA_BITS = 8
);
  localparam int ID_BITS = (NUM_PORTS > 1) ? $clog2(NUM_PORTS) : 1;

  logic [NUM_PORTS*DATA_BITS-1:0] saxis_tdata;
  logic [NUM_PORTS-1:0]           saxis_tvalid;
  logic [NUM_PORTS-1:0]           saxis_tlast;
  logic [NUM_PORTS-1:0]           saxis_tready;
  logic [DATA_BITS-1:0]           maxis_tdata;
  logic                           maxis_tlast;
  logic [ID_BITS-1:0]             maxis_tid;
  logic                           maxis_tvalid;
  logic                           maxis_tready;

  // Arbiter side
  modport slave (
    input  saxis_tdata, saxis_tvalid, saxis_tlast, maxis_tready,
    output saxis_tready, maxis_tdata, maxis_tlast, maxis_tid, maxis_tvalid
  );

  // Producer/consumer side
  modport master (
    output saxis_tdata, saxis_tvalid, saxis_tlast, maxis_tready,
    input  saxis_tready, maxis_tdata, maxis_tlast, maxis_tid, maxis_tvalid
  );
endinterface

// File: rtl/stream_packet_arbiter.sv
// Round-robin, packet-aware N:1 AXI4-Stream arbiter with one registered
// output stage. A grant is held from the first beat of a packet to its tlast.
module stream_packet_arbiter #(
  parameter int NUM_PORTS = 4,
  parameter int DATA_BITS = 8
) (
  input logic                     clock,
  input logic                     reset,
  stream_packet_arbiter_if.slave  bus
);
  localparam int          ID_BITS = (NUM_PORTS > 1) ? $clog2(NUM_PORTS) : 1;
  localparam int unsigned NP_U    = NUM_PORTS;

  typedef enum logic {S_IDLE, S_LOCKED} state_t;

  state_t                 r_state;
  logic [ID_BITS-1:0]     r_grant;
  logic [ID_BITS-1:0]     r_rr_ptr;
  logic [DATA_BITS-1:0]   r_tdata;
  logic                   r_tlast;
  logic [ID_BITS-1:0]     r_tid;
  logic                   r_tvalid;

  logic                   w_out_free;
  logic                   w_found;
  logic [ID_BITS-1:0]     w_cand;
  logic [ID_BITS-1:0]     w_sel;
  logic [NUM_PORTS-1:0]   w_ready;
  logic                   w_hs;
  logic [DATA_BITS-1:0]   w_sel_data;
  logic                   w_sel_last;

  function automatic logic [ID_BITS-1:0] next_port(input logic [ID_BITS-1:0] p);
    return ((32'(p) + 32'd1) >= NP_U) ? '0 : p + ID_BITS'(1);
  endfunction

  assign w_out_free = !r_tvalid || bus.maxis_tready;
  assign w_sel      = (r_state == S_LOCKED) ? r_grant : w_cand;
  assign w_hs       = |(w_ready & bus.saxis_tvalid);

  // Candidate: first valid port scanning from rr_ptr with an explicit modulo wrap
  always_comb begin
    int unsigned        idx;
    logic [ID_BITS-1:0] idx_id;
    w_found = 1'b0;
    w_cand  = '0;
    for (int unsigned i = 0; i < NP_U; i++) begin
      idx = 32'(r_rr_ptr) + i;
      if (idx >= NP_U) idx = idx - NP_U;
      idx_id = ID_BITS'(idx);
      if (!w_found && bus.saxis_tvalid[idx_id]) begin
        w_found = 1'b1;
        w_cand  = idx_id;
      end
    end
  end

  // Ready goes only to the locked port or the candidate, never during reset
  always_comb begin
    w_ready = '0;
    if (!reset) begin
      if (r_state == S_LOCKED) w_ready[r_grant] = w_out_free;
      else if (w_found)        w_ready[w_cand]  = w_out_free;
    end
  end

  // Beat mux for the selected port
  always_comb begin
    w_sel_data = '0;
    w_sel_last = 1'b0;
    for (int unsigned p = 0; p < NP_U; p++) begin
      if (ID_BITS'(p) == w_sel) begin
        w_sel_data = bus.saxis_tdata[p*DATA_BITS +: DATA_BITS];
        w_sel_last = bus.saxis_tlast[p];
      end
    end
  end

  // Arbitration FSM and output register; grant/pointer change only on handshakes
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_state  <= S_IDLE;
      r_grant  <= '0;
      r_rr_ptr <= '0;
      r_tvalid <= 1'b0;
      r_tdata  <= '0;
      r_tlast  <= 1'b0;
      r_tid    <= '0;
    end else begin
      if (w_hs) begin
        r_tdata  <= w_sel_data;
        r_tlast  <= w_sel_last;
        r_tid    <= w_sel;
        r_tvalid <= 1'b1;
        if (w_sel_last) begin
          r_state  <= S_IDLE;
          r_rr_ptr <= next_port(w_sel);
        end else begin
          r_state  <= S_LOCKED;
          r_grant  <= w_sel;
        end
      end else if (bus.maxis_tready) begin
        r_tvalid <= 1'b0;
      end
    end
  end

  assign bus.saxis_tready = w_ready;
  assign bus.maxis_tdata  = r_tdata;
  assign bus.maxis_tlast  = r_tlast;
  assign bus.maxis_tid    = r_tid;
  assign bus.maxis_tvalid = r_tvalid;
endmodule

// File: tb/tb_stream_packet_arbiter.sv
// Bench for stream_packet_arbiter: randomized producers against a behavioural
// arbitration model and per-port scoreboard, plus directed literal sequences.
module tb_stream_packet_arbiter;
  localparam int NP = 4;
  localparam int DB = 8;

  logic clock = 1'b0;
  logic reset = 1'b1;
  logic reset3 = 1'b1;
  always #5 clock = ~clock;

  stream_packet_arbiter_if #(.NUM_PORTS(NP), .DATA_BITS(DB)) bus ();
  stream_packet_arbiter #(.NUM_PORTS(NP), .DATA_BITS(DB)) dut (
    .clock(clock), .reset(reset), .bus(bus)
  );

  stream_packet_arbiter_if #(.NUM_PORTS(3), .DATA_BITS(DB)) bus3 ();
  stream_packet_arbiter #(.NUM_PORTS(3), .DATA_BITS(DB)) dut3 (
    .clock(clock), .reset(reset3), .bus(bus3)
  );

  int n_checks = 0;
  int n_fail   = 0;

  // Model of the arbiter's externally visible behaviour
  bit       m_locked;
  int       m_g, m_ptr, m_id;
  bit       m_v, m_l;
  logic [7:0] m_d;

  // Producers
  bit         s_v[NP], s_l[NP];
  logic [7:0] s_d[NP];
  logic [5:0] s_seq[NP];
  int         s_rem[NP];
  int         en_pct[NP], len_lo[NP], len_hi[NP];
  int         rdy_pct;

  // Scoreboard
  logic [8:0] q[NP][$];
  int         log_tid[$];
  int         open_pkt;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic drive();
    for (int p = 0; p < NP; p++) begin
      bus.saxis_tdata[p*DB +: DB] = s_d[p];
      bus.saxis_tvalid[p]         = s_v[p];
      bus.saxis_tlast[p]          = s_l[p];
    end
  endtask

  task automatic gen_inputs();
    for (int p = 0; p < NP; p++) begin
      if (!s_v[p] && int'($urandom % 100) < en_pct[p]) begin
        if (s_rem[p] == 0) s_rem[p] = $urandom_range(len_hi[p], len_lo[p]);
        s_v[p] = 1'b1;
        s_d[p] = {p[1:0], s_seq[p]};
        s_l[p] = (s_rem[p] == 1);
      end
    end
    bus.maxis_tready = int'($urandom % 100) < rdy_pct;
    drive();
  endtask

  task automatic set_cfg(input int en, input int lo, input int hi, input int rdy);
    for (int p = 0; p < NP; p++) begin
      en_pct[p] = en; len_lo[p] = lo; len_hi[p] = hi;
    end
    rdy_pct = rdy;
  endtask

  // One clock cycle: compare at the falling edge, advance model after the rising edge
  task automatic cycle();
    logic [NP-1:0] er;
    int  c, acc, tid;
    bit  of, tr;
    @(negedge clock);
    er = '0; acc = -1; c = -1;
    tr = bus.maxis_tready;
    of = !m_v || tr;
    if (m_locked) c = m_g;
    else for (int k = 0; k < NP; k++) if (c < 0 && s_v[(m_ptr + k) % NP]) c = (m_ptr + k) % NP;
    if (c >= 0) begin
      er[c] = of;
      if (of && s_v[c]) acc = c;
    end
    chk("s_tready", bus.saxis_tready, er);
    chk("m_tvalid", bus.maxis_tvalid, m_v);
    if (m_v) begin
      chk("m_tdata", bus.maxis_tdata, m_d);
      chk("m_tlast", bus.maxis_tlast, m_l);
      chk("m_tid", bus.maxis_tid, m_id);
    end
    if (bus.maxis_tvalid && tr) begin
      tid = int'(bus.maxis_tid);
      if (q[tid].size() == 0) chk("sb_extra_beat", {bus.maxis_tlast, bus.maxis_tdata}, 9'h1ff);
      else chk("sb_beat", {bus.maxis_tlast, bus.maxis_tdata}, q[tid].pop_front());
      if (open_pkt >= 0) chk("no_interleave", tid, open_pkt);
      open_pkt = bus.maxis_tlast ? -1 : tid;
      log_tid.push_back(tid);
    end
    @(posedge clock); #1;
    if (m_v && tr) m_v = 1'b0;
    if (acc >= 0) begin
      m_v = 1'b1; m_d = s_d[acc]; m_l = s_l[acc]; m_id = acc;
      q[acc].push_back({s_l[acc], s_d[acc]});
      if (s_l[acc]) begin m_locked = 1'b0; m_ptr = (acc + 1) % NP; end
      else begin m_locked = 1'b1; m_g = acc; end
      s_v[acc] = 1'b0; s_rem[acc]--; s_seq[acc]++;
    end
    gen_inputs();
  endtask

  // Reset asserted mid-cycle; outputs must clear before any clock edge
  task automatic do_reset();
    #2; reset = 1'b1; #1;
    chk("rst_tvalid", bus.maxis_tvalid, 0);
    chk("rst_tdata", bus.maxis_tdata, 0);
    chk("rst_tlast", bus.maxis_tlast, 0);
    chk("rst_tid", bus.maxis_tid, 0);
    chk("rst_tready", bus.saxis_tready, 0);
    m_v = 0; m_d = '0; m_l = 0; m_id = 0; m_locked = 0; m_g = 0; m_ptr = 0; open_pkt = -1;
    for (int p = 0; p < NP; p++) begin
      q[p].delete(); s_v[p] = 0; s_rem[p] = 0;
    end
    log_tid.delete();
    @(posedge clock); #1;
    reset = 1'b0;
    gen_inputs();
  endtask

  task automatic step3(input logic [2:0] v, input logic [2:0] l, input logic [2:0] er,
                       input logic ev, input int eid, input logic el);
    bus3.saxis_tvalid = v; bus3.saxis_tlast = l; #1;
    chk("np3_tready", bus3.saxis_tready, er);
    @(posedge clock); #1;
    chk("np3_tvalid", bus3.maxis_tvalid, ev);
    if (ev) begin
      chk("np3_tid", bus3.maxis_tid, eid);
      chk("np3_tdata", bus3.maxis_tdata, 8'hA0 + eid);
      chk("np3_tlast", bus3.maxis_tlast, el);
    end
  endtask

  initial begin
    int exp_rr[6]  = '{0, 1, 2, 3, 0, 1};
    int exp_lk[5]  = '{2, 2, 2, 3, 0};
    logic [7:0] d0;
    int id0, n0, total;

    m_v = 0; m_d = '0; m_l = 0; m_id = 0; m_locked = 0; m_g = 0; m_ptr = 0; open_pkt = -1;
    for (int p = 0; p < NP; p++) begin
      s_v[p] = 0; s_l[p] = 0; s_d[p] = '0; s_seq[p] = '0; s_rem[p] = 0;
    end
    bus.maxis_tready = 1'b0;
    drive();
    bus3.saxis_tdata = {8'hA2, 8'hA1, 8'hA0};
    bus3.saxis_tvalid = '0; bus3.saxis_tlast = '0; bus3.maxis_tready = 1'b1;

    repeat (2) @(posedge clock);
    #1;
    chk("init_tvalid", bus.maxis_tvalid, 0);
    chk("init_tdata", bus.maxis_tdata, 0);
    chk("init_tid", bus.maxis_tid, 0);
    chk("init_tready", bus.saxis_tready, 0);
    reset = 1'b0;

    // Warm-up traffic so the reset check sees live state
    set_cfg(60, 1, 4, 70);
    gen_inputs();
    repeat (200) cycle();

    // Reset mid-traffic, then round-robin over single-beat packets
    set_cfg(100, 1, 1, 100);
    do_reset();
    repeat (8) cycle();
    chk("rr_count", log_tid.size() >= 6, 1);
    for (int i = 0; i < 6 && i < log_tid.size(); i++) chk("rr_tid", log_tid[i], exp_rr[i]);

    // Backpressure with a beat held on the output
    rdy_pct = 0; bus.maxis_tready = 1'b0;
    d0 = bus.maxis_tdata; id0 = int'(bus.maxis_tid);
    chk("bp_hold_valid", bus.maxis_tvalid, 1);
    repeat (5) begin
      cycle();
      chk("bp_tdata_stable", bus.maxis_tdata, d0);
      chk("bp_tid_stable", bus.maxis_tid, id0);
      chk("bp_tready_zero", bus.saxis_tready, 0);
    end
    rdy_pct = 100; bus.maxis_tready = 1'b1;
    n0 = log_tid.size();
    cycle();
    chk("bp_release_valid", bus.maxis_tvalid, 1);
    chk("bp_release_consumed", log_tid.size() - n0, 1);

    // Packet locking: 3-beat packet on port 2 while ports 0 and 3 wait
    set_cfg(0, 1, 1, 100);
    en_pct[2] = 100; len_lo[2] = 3; len_hi[2] = 3;
    do_reset();
    cycle();
    en_pct[0] = 100; en_pct[3] = 100;
    gen_inputs();
    repeat (7) cycle();
    chk("lock_count", log_tid.size() >= 5, 1);
    for (int i = 0; i < 5 && i < log_tid.size(); i++) chk("lock_tid", log_tid[i], exp_lk[i]);

    // Randomized traffic with bubbles and backpressure
    set_cfg(50, 1, 5, 70);
    gen_inputs();
    repeat (10000) cycle();

    // Drain: every accepted beat must have been delivered
    set_cfg(0, 1, 1, 100);
    gen_inputs();
    repeat (10) cycle();
    total = 0;
    for (int p = 0; p < NP; p++) total += q[p].size();
    chk("drain_empty", total, 0);

    // Three ports: explicit wrap and a held grant across a 2-cycle bubble
    reset3 = 1'b0;
    step3(3'b111, 3'b111, 3'b001, 1, 0, 1);
    step3(3'b111, 3'b111, 3'b010, 1, 1, 1);
    step3(3'b111, 3'b111, 3'b100, 1, 2, 1);
    step3(3'b111, 3'b111, 3'b001, 1, 0, 1);
    step3(3'b111, 3'b101, 3'b010, 1, 1, 0);
    step3(3'b101, 3'b111, 3'b010, 0, 0, 0);
    step3(3'b101, 3'b111, 3'b010, 0, 0, 0);
    step3(3'b111, 3'b111, 3'b010, 1, 1, 1);
    step3(3'b111, 3'b111, 3'b100, 1, 2, 1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule

// File: doc/stream_packet_arbiter.md
# stream_packet_arbiter

Round-robin, packet-aware N:1 arbiter that shares a single downstream AXI4-Stream consumer (typically a `simple_fifo` instance or a serializer behind one) between `NUM_PORTS` upstream producers. A grant is held from the first beat of a packet until its `tlast` beat, so packets from different sources never interleave. The output passes through one registered stage that sustains one beat per cycle. The winning source index is reported on `maxis_tid`.

## Interface
- `NUM_PORTS`, default 4: number of upstream stream ports, ≥1.
- `DATA_BITS`, default 8: beat width.
- `ID_BITS` (localparam): `max(1, $clog2(NUM_PORTS))`.

Ports:
- `clock`: input, 1 bit. The single clock; all state changes on its rising edge.
- `reset`: input, 1 bit. Asynchronous, active-high reset.
- `saxis_tdata`: input, `NUM_PORTS*DATA_BITS`. Port p occupies bits `[p*DATA_BITS +: DATA_BITS]`.
- `saxis_tvalid`: input, `NUM_PORTS`. Per-port valid.
- `saxis_tlast`: input, `NUM_PORTS`. Per-port end of packet.
- `saxis_tready`: output, `NUM_PORTS`. Per-port ready; at most one bit is high.
- `maxis_tdata`: output, `DATA_BITS`. Registered beat.
- `maxis_tlast`: output, 1 bit. Registered end of packet.
- `maxis_tid`: output, `ID_BITS`. Source port of the current beat.
- `maxis_tvalid`: output, 1 bit. Registered valid.
- `maxis_tready`: input, 1 bit. Downstream ready.

## Operation
- Internal state:
  - `state`: IDLE or LOCKED.
  - `grant`: `ID_BITS` wide; the locked port.
  - `rr_ptr`: `ID_BITS` wide; highest-priority port for the next arbitration.
- `out_free = !maxis_tvalid || maxis_tready`.
- **IDLE:**
  - Candidate is the first port p with `saxis_tvalid[p]`, scanning `rr_ptr, rr_ptr+1, …` modulo `NUM_PORTS`. The wrap is explicit, so non-power-of-2 `NUM_PORTS` never selects a port ≥ `NUM_PORTS`.
  - `saxis_tready[candidate] = out_free`; all other ready bits are 0. If no port is valid, all ready bits are 0.
  - On a handshake with `tlast=0`: go to LOCKED and set `grant <= candidate`.
  - On a handshake with `tlast=1` (single-beat packet): stay in IDLE and set `rr_ptr <= candidate+1` (mod `NUM_PORTS`).
- **LOCKED:**
  - `saxis_tready[grant] = out_free`; all other ready bits are 0, whatever their `tvalid`.
  - On a handshake with `tlast=1`: go to IDLE and set `rr_ptr <= grant+1` (mod `NUM_PORTS`).
  - If the granted port drops `tvalid` mid-packet, the grant is held. This creates bubbles only; there is no timeout.
- **Output register**, on any input handshake from port p:
  - `maxis_tdata <= data_p`, `maxis_tlast <= tlast_p`, `maxis_tid <= p`, `maxis_tvalid <= 1`.
  - Otherwise, if `maxis_tready` is high, `maxis_tvalid <= 0`, and data/last/id hold their values.
- `saxis_tready` is a combinational function of state, `saxis_tvalid`, `maxis_tvalid` and `maxis_tready`. It never depends on `saxis_tdata` or `saxis_tlast`.
- Single-port configuration (`NUM_PORTS=1`): `maxis_tid` is constantly 0, and the block degenerates to a registered pass-through with packet tracking.

## Timing
- Reset values, applied asynchronously:
  - `state` = IDLE; `grant` = 0; `rr_ptr` = 0.
  - `maxis_tvalid` = 0, `maxis_tdata` = 0, `maxis_tlast` = 0, `maxis_tid` = 0.
  - `saxis_tready` = all 0 while `reset` is high.
- Latency: a beat accepted at edge n is presented on `maxis_*` after edge n, and the downstream can consume it at edge n+1.
- Throughput: one beat per cycle with `maxis_tready` held high, including back-to-back packets from different ports. There is no arbitration bubble between packets.
- Backpressure: while `maxis_tvalid && !maxis_tready`, all `saxis_tready` bits are 0 and `maxis_*` are stable.
- Simultaneous output consume and input accept in the same cycle: the register is reloaded and `maxis_tvalid` stays 1.
- Reset asserted mid-packet:
  - The partial packet's downstream beat is dropped and the grant is released.
  - After reset, arbitration restarts at port 0.
  - The upstream is responsible for discarding its remainder.
- Grant changes and `rr_ptr` updates take effect only at `tlast` handshakes. Arrivals of `tvalid` on other ports never preempt a locked grant.

## Test plan
- **Reset defaults.** Assert `reset` mid-cycle with ports valid → all outputs drop to 0 immediately (asynchronously); after release, the first grant goes to port 0 when ports 0–3 are all valid.
- **Round-robin fairness.** All 4 ports continuously send 1-beat packets (`tlast=1`), `maxis_tready=1` → `maxis_tid` sequence is 0,1,2,3,0,1 with `maxis_tvalid` high every cycle.
- **Packet locking.** Port 2 sends a 3-beat packet (A0, A1, A2 with last) while port 0 is valid throughout → output shows A0, A1, A2 with `tid=2` and no interleave; the next `tid` is 3 if port 3 is valid, otherwise 0.
- **Backpressure.** Hold `maxis_tready=0` for 5 cycles with a beat held on the output → `maxis_tdata`/`maxis_tid` are stable and all `saxis_tready` bits are 0. On release, the next beat follows in the same cycle with no loss or duplication.
- **Non-power-of-2 wrap and mid-packet bubble.**
  - `NUM_PORTS=3`, all ports valid → `tid` sequence is 0,1,2,0 and never 3.
  - The locked port deasserts `tvalid` for 2 cycles → output bubbles for 2 cycles and the grant is kept.
- **Randomized scoreboard.** Random valid/last/ready over 10k cycles → every input beat appears exactly once, per-port order is preserved, and no packet interleaves.
